// File: rtl/fp32_to_bf16_feeder_pkg.sv
// Shared definitions for the FP32 -> BF16 operand feeder.
// Holds the feeder FSM state encoding and the floating-point constants used
// by the converter. No ports; imported by every design unit of the feeder.
package fp32_to_bf16_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_A = 2'd1,
        CONV_B = 2'd2,
        OFFER  = 2'd3
    } state_e;

    // Canonical quiet-NaN magnitude; the sign of the source NaN is kept.
    localparam logic [15:0] QNAN_BF16_DEFAULT = 16'h7FC0;
    localparam logic [15:0] BF16_INF          = 16'h7F80;
    localparam logic [7:0]  FP32_EXP_ONES     = 8'hFF;

endpackage

// File: rtl/fp32_to_bf16_feeder_if.sv
// Operand/handshake bundle between an upstream producer, the feeder and the
// downstream adder.
//   input_a/input_b     : FP32 operands (BF16 in [15:0] when input_fmt=1)
//   input_fmt           : 0 = FP32, 1 = BF16 passthrough
//   feeder_input_STB    : upstream operands valid
//   feeder_BUSY         : feeder cannot accept operands
//   output_a/output_b   : BF16 operands to the adder
//   feeder_output_STB   : output_a/output_b valid
//   adder_BUSY          : adder cannot take operands
//   inexact             : a latched FP32 operand lost nonzero bits
// master = producer/adder side, slave = the feeder.
interface fp32_to_bf16_feeder_if;

    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        input_fmt;
    logic        feeder_input_STB;
    logic        feeder_BUSY;
    logic [15:0] output_a;
    logic [15:0] output_b;
    logic        feeder_output_STB;
    logic        adder_BUSY;
    logic        inexact;

    modport master (
        output input_a, input_b, input_fmt, feeder_input_STB, adder_BUSY,
        input  feeder_BUSY, output_a, output_b, feeder_output_STB, inexact
    );

    modport slave (
        input  input_a, input_b, input_fmt, feeder_input_STB, adder_BUSY,
        output feeder_BUSY, output_a, output_b, feeder_output_STB, inexact
    );

endinterface

// File: rtl/fp32_to_bf16_rne.sv
// Combinational FP32 -> BF16 conversion, round-to-nearest-even.
//   value_i   : FP32 value
//   result_o  : BF16 result
//   inexact_o : guard or sticky bits were nonzero (never set for NaN)
// NaNs become {sign, QNAN_BF16[14:0]}. Everything else, including infinity,
// zeros and subnormals, goes through the same rounding add.
module fp32_to_bf16_rne
    import fp32_to_bf16_feeder_pkg::*;
#(
    parameter logic [15:0] QNAN_BF16 = QNAN_BF16_DEFAULT
) (
    input  logic [31:0] value_i,
    output logic [15:0] result_o,
    output logic        inexact_o
);

    logic is_nan;
    logic lsb;
    logic guard;
    logic sticky;
    logic round_up;

    assign is_nan   = (value_i[30:23] == FP32_EXP_ONES) && (value_i[22:0] != 23'd0);
    assign lsb      = value_i[16];
    assign guard    = value_i[15];
    assign sticky   = |value_i[14:0];
    assign round_up = guard & (sticky | lsb);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; a missed branch would otherwise infer a latch.
        result_o  = value_i[31:16];
        inexact_o = 1'b0;
        if (is_nan) begin
            result_o = {value_i[31], QNAN_BF16[14:0]};
        end else begin
            // A mantissa carry ripples into the exponent, so 0x7F7F/0xFF7F
            // rounding up lands exactly on signed infinity (BF16_INF).
            result_o  = value_i[31:16] + {15'd0, round_up};
            inexact_o = guard | sticky;
        end
    end

endmodule

// File: rtl/fp32_to_bf16_feeder.sv
// Operand feeder: accepts an FP32 (or BF16) operand pair, converts A then B
// through one shared rounder, and offers the BF16 pair to the adder.
//   clk : clock, all state on its rising edge
//   rst : synchronous, active-high reset
//   bus : operand/handshake bundle (slave side)
// Accept at edge N -> output_a written at N+1, output_b at N+2, STB high
// from then on and seen by the adder at edge N+3.
module fp32_to_bf16_feeder
    import fp32_to_bf16_feeder_pkg::*;
#(
    parameter logic [15:0] QNAN_BF16 = QNAN_BF16_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    fp32_to_bf16_feeder_if.slave        bus
);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        fmt_q, fmt_d;
    logic [15:0] out_a_q, out_a_d;
    logic [15:0] out_b_q, out_b_d;
    logic        stb_q, stb_d;
    logic        busy_q, busy_d;
    logic        inexact_q, inexact_d;

    logic [31:0] conv_in;
    logic [15:0] conv_res;
    logic        conv_inexact;
    logic [15:0] conv_bf16;
    logic        conv_lost;

    // One rounder, time-shared: A during CONV_A, B during CONV_B.
    assign conv_in = (state_q == CONV_B) ? b_q : a_q;

    fp32_to_bf16_rne #(
        .QNAN_BF16 (QNAN_BF16)
    ) u_rne (
        .value_i   (conv_in),
        .result_o  (conv_res),
        .inexact_o (conv_inexact)
    );

    // BF16 passthrough bypasses rounding and never reports inexact.
    assign conv_bf16 = fmt_q ? conv_in[15:0] : conv_res;
    assign conv_lost = fmt_q ? 1'b0 : conv_inexact;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        fmt_d     = fmt_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        stb_d     = stb_q;
        busy_d    = busy_q;
        inexact_d = inexact_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (!busy_q && bus.feeder_input_STB) begin
                    a_d       = bus.input_a;
                    b_d       = bus.input_b;
                    fmt_d     = bus.input_fmt;
                    busy_d    = 1'b1;
                    inexact_d = 1'b0;
                    state_d   = CONV_A;
                end
            end
            CONV_A: begin
                out_a_d   = conv_bf16;
                inexact_d = inexact_q | conv_lost;
                state_d   = CONV_B;
            end
            CONV_B: begin
                out_b_d   = conv_bf16;
                inexact_d = inexact_q | conv_lost;
                stb_d     = 1'b1;
                state_d   = OFFER;
            end
            OFFER: begin
                // Everything holds while the adder is busy.
                if (stb_q && !bus.adder_BUSY) begin
                    stb_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset clears the latched operands too, so nothing from an interrupted
    // transfer can resurface after reset release.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            fmt_q     <= 1'b0;
            out_a_q   <= 16'd0;
            out_b_q   <= 16'd0;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            fmt_q     <= fmt_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            stb_q     <= stb_d;
            busy_q    <= busy_d;
            inexact_q <= inexact_d;
        end
    end

    assign bus.output_a          = out_a_q;
    assign bus.output_b          = out_b_q;
    assign bus.feeder_output_STB = stb_q;
    assign bus.feeder_BUSY       = busy_q;
    assign bus.inexact           = inexact_q;

endmodule

// File: tb/tb_fp32_to_bf16_feeder.sv
// Self-checking bench for fp32_to_bf16_feeder: a table of operand pairs with
// hand-computed BF16 results, plus backpressure and mid-conversion reset
// sequences.
module tb_fp32_to_bf16_feeder;

    logic clk = 1'b0;
    logic rst;

    fp32_to_bf16_feeder_if bus ();

    fp32_to_bf16_feeder #(
        .QNAN_BF16 (16'h7FC0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        fmt;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_inexact;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input string name, input logic [31:0] a,
                           input logic [31:0] b, input logic fmt, input logic [15:0] ea,
                           input logic [15:0] eb, input logic ei);
        vecs[i].name        = name;
        vecs[i].a           = a;
        vecs[i].b           = b;
        vecs[i].fmt         = fmt;
        vecs[i].exp_a       = ea;
        vecs[i].exp_b       = eb;
        vecs[i].exp_inexact = ei;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pair while the feeder is idle and walk to the cycle where STB
    // is first high (registered at edge N+2, sampled by the adder at N+3).
    task automatic issue(input vec_t v);
        bus.input_a          = v.a;
        bus.input_b          = v.b;
        bus.input_fmt        = v.fmt;
        bus.feeder_input_STB = 1'b1;
        step();                                   // edge N: accepted
        bus.feeder_input_STB = 1'b0;
        check({v.name, ".busy@N"}, bus.feeder_BUSY, 1);
        check({v.name, ".stb@N"}, bus.feeder_output_STB, 0);
        step();                                   // edge N+1
        check({v.name, ".stb@N+1"}, bus.feeder_output_STB, 0);
        step();                                   // edge N+2
        check({v.name, ".stb@N+3"}, bus.feeder_output_STB, 1);
    endtask

    task automatic check_data(input vec_t v, input string tag);
        check({v.name, tag, ".out_a"}, bus.output_a, v.exp_a);
        check({v.name, tag, ".out_b"}, bus.output_b, v.exp_b);
        check({v.name, tag, ".inexact"}, bus.inexact, v.exp_inexact);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".stb"},     bus.feeder_output_STB, 0);
        check({tag, ".busy"},    bus.feeder_BUSY, 0);
        check({tag, ".inexact"}, bus.inexact, 0);
        check({tag, ".out_a"},   bus.output_a, 0);
        check({tag, ".out_b"},   bus.output_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //      name         a             b             fmt  exp_a     exp_b     inexact
        set_vec(0,  "unit",     32'h3F800000, 32'hC0000000, 0, 16'h3F80, 16'hC000, 0);
        set_vec(1,  "ties",     32'h3F808000, 32'h3F818000, 0, 16'h3F80, 16'h3F82, 1);
        set_vec(2,  "specials", 32'h7F7FFFFF, 32'hFFA00001, 0, 16'h7F80, 16'hFFC0, 1);
        set_vec(3,  "pass",     32'h00007FA1, 32'h00008000, 1, 16'h7FA1, 16'h8000, 0);
        set_vec(4,  "zeros",    32'h80000000, 32'h00000000, 0, 16'h8000, 16'h0000, 0);
        set_vec(5,  "inf",      32'h7F800000, 32'hFF800000, 0, 16'h7F80, 16'hFF80, 0);
        set_vec(6,  "subnorm",  32'h0000FFFF, 32'h807F8001, 0, 16'h0001, 16'h8080, 1);
        set_vec(7,  "rnd_down", 32'h3F807FFF, 32'h40490FDB, 0, 16'h3F80, 16'h4049, 1);
        set_vec(8,  "neg_ovf",  32'hFF7F8000, 32'h7FC00000, 0, 16'hFF80, 16'h7FC0, 1);
        set_vec(9,  "nan_exact",32'h7F800001, 32'h3F800000, 0, 16'h7FC0, 16'h3F80, 0);
        set_vec(10, "carry",    32'h3F7FFFFF, 32'h00008000, 0, 16'h3F80, 16'h0000, 1);
        set_vec(11, "pass_nan", 32'hABCD7F81, 32'h1234FFFF, 1, 16'h7F81, 16'hFFFF, 0);

        rst                  = 1'b1;
        bus.input_a          = 32'd0;
        bus.input_b          = 32'd0;
        bus.input_fmt        = 1'b0;
        bus.feeder_input_STB = 1'b0;
        bus.adder_BUSY       = 1'b0;
        step();
        step();
        check_reset_state("reset");
        rst = 1'b0;
        step();
        check("post_reset.stb", bus.feeder_output_STB, 0);

        // Table: each pair accepted, converted, then taken immediately.
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i]);
            check_data(vecs[i], "");
            step();                               // edge N+3: handshake
            check({vecs[i].name, ".stb_clr"}, bus.feeder_output_STB, 0);
            check({vecs[i].name, ".busy_clr"}, bus.feeder_BUSY, 0);
        end

        // Backpressure: adder busy for 5 cycles while a new upstream STB
        // with different data is asserted; nothing may move.
        bus.adder_BUSY = 1'b1;
        issue(vecs[2]);
        bus.input_a          = vecs[0].a;
        bus.input_b          = vecs[0].b;
        bus.input_fmt        = 1'b0;
        bus.feeder_input_STB = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp.stb", bus.feeder_output_STB, 1);
            check("bp.busy", bus.feeder_BUSY, 1);
            check_data(vecs[2], ".bp");
        end
        bus.adder_BUSY = 1'b0;
        step();                                   // handshake edge
        bus.feeder_input_STB = 1'b0;
        check("bp_rel.stb", bus.feeder_output_STB, 0);
        check("bp_rel.busy", bus.feeder_BUSY, 0);
        step();
        check("bp_idle.stb", bus.feeder_output_STB, 0);
        check("bp_idle.busy", bus.feeder_BUSY, 0);
        check("bp_idle.out_a", bus.output_a, vecs[2].exp_a);

        // Reset while in CONV_B: everything returns to reset values and no
        // STB appears until a fresh handshake.
        bus.input_a          = vecs[1].a;
        bus.input_b          = vecs[1].b;
        bus.input_fmt        = vecs[1].fmt;
        bus.feeder_input_STB = 1'b1;
        step();                                   // edge N: accepted
        bus.feeder_input_STB = 1'b0;
        step();                                   // edge N+1: now in CONV_B
        check("rst_mid.out_a_written", bus.output_a, vecs[1].exp_a);
        rst = 1'b1;
        step();
        check_reset_state("rst_mid");
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("rst_quiet.stb", bus.feeder_output_STB, 0);
            check("rst_quiet.busy", bus.feeder_BUSY, 0);
        end
        issue(vecs[0]);
        check_data(vecs[0], ".after_rst");
        step();
        check("after_rst.stb_clr", bus.feeder_output_STB, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_to_bf16_feeder.md
FP32_TO_BF16_FEEDER -- requirements
Module: fp32_to_bf16_feeder

Interface
REQ-001 SHALL have parameter QNAN_BF16, default 16'h7FC0, the canonical quiet-NaN magnitude emitted for any NaN input.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port input_a  input  32  operand A (FP32, or BF16 in bits [15:0] when input_fmt=1).
REQ-005 SHALL have port input_b  input  32  operand B, same format as input_a.
REQ-006 SHALL have port input_fmt  input  1  0 = FP32 operands, 1 = BF16 passthrough.
REQ-007 SHALL have port feeder_input_STB  input  1  upstream operands valid.
REQ-008 SHALL have port feeder_BUSY  output  1  feeder cannot accept operands.
REQ-009 SHALL have port output_a  output  16  BF16 operand A to the adder.
REQ-010 SHALL have port output_b  output  16  BF16 operand B to the adder.
REQ-011 SHALL have port feeder_output_STB  output  1  output_a/output_b valid.
REQ-012 SHALL have port adder_BUSY  input  1  downstream adder busy.
REQ-013 SHALL have port inexact  output  1  set when either latched FP32 operand lost nonzero bits in rounding.

Function
REQ-014 SHALL implement states IDLE, CONV_A, CONV_B, OFFER.
REQ-015 In IDLE, feeder_BUSY SHALL be driven 0 on each clock; when feeder_BUSY==0 and feeder_input_STB==1, SHALL latch input_a, input_b, input_fmt, set feeder_BUSY=1, clear inexact, and go to CONV_A.
REQ-016 CONV_A SHALL write the converted A into output_a in one cycle and go to CONV_B; CONV_B SHALL do the same for B into output_b and go to OFFER.
REQ-017 Latency: accept at edge N; feeder_output_STB SHALL be 1 from edge N+3.
REQ-018 In OFFER, feeder_output_STB SHALL be 1; when feeder_output_STB==1 and adder_BUSY==0 at an edge, SHALL clear feeder_output_STB and return to IDLE at that edge.
REQ-019 While adder_BUSY==1 in OFFER, output_a, output_b, inexact and feeder_output_STB SHALL hold unchanged for any number of cycles.
REQ-020 feeder_input_STB SHALL be ignored in all states other than IDLE and whenever feeder_BUSY==1.
REQ-021 FP32 conversion SHALL be round-to-nearest-even: lsb=x[16], guard=x[15], sticky=|x[14:0]; result = x[31:16] + (guard & (sticky | lsb)).
REQ-022 Mantissa carry SHALL propagate into the exponent; finite values rounding past 0x7F7F SHALL become signed infinity (0x7F80/0xFF80).
REQ-023 FP32 NaN (exp=0xFF, mantissa!=0) SHALL yield {sign, QNAN_BF16[14:0]}, no rounding, inexact unaffected.
REQ-024 FP32 infinity, zeros and subnormals SHALL use REQ-021 unchanged (subnormals not flushed; signed zero preserved).
REQ-025 inexact SHALL be set if guard|sticky nonzero for a non-NaN FP32 operand.
REQ-026 input_fmt=1 SHALL pass bits [15:0] through unmodified (NaNs not canonicalised), inexact=0.

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE, feeder_BUSY=0, feeder_output_STB=0, inexact=0, output_a=0, output_b=0, taking priority over all other updates.
REQ-028 Reset mid-CONV or mid-OFFER SHALL discard the latched operands; no STB pulse SHALL follow reset release without a new input handshake.

Structure
REQ-029 A shared package SHALL hold the state encodings, QNAN_BF16 default, BF16 infinity constant 16'h7F80 and FP32 exponent-all-ones constant 8'hFF.
REQ-030 Rounding SHALL be a single combinational sub-module fp32_to_bf16_rne (in: 32-bit value; out: 16-bit result, inexact bit), instantiated once and time-shared across CONV_A/CONV_B.

Verification
REQ-031 input_a=0x3F800000, input_b=0xC0000000, fmt=0, adder_BUSY=0 -> STB at N+3, output_a=0x3F80, output_b=0xC000, inexact=0.
REQ-032 Ties: input_a=0x3F808000, input_b=0x3F818000 -> output_a=0x3F80, output_b=0x3F82, inexact=1.
REQ-033 Specials: input_a=0x7F7FFFFF, input_b=0xFFA00001 -> output_a=0x7F80, output_b=0xFFC0.
REQ-034 Backpressure: adder_BUSY=1 for 5 cycles in OFFER -> STB and data stable all 5 cycles; adder_BUSY=0 -> STB clears same edge, feeder_BUSY=0 next cycle.
REQ-035 rst pulsed during CONV_B -> next cycle all outputs at reset values; no STB until a new feeder_input_STB handshake.
REQ-036 Passthrough: fmt=1, input_a=0x0000_7FA1, input_b=0x0000_8000 -> output_a=0x7FA1, output_b=0x8000, inexact=0.
